// File: rtl/clock_time_ctrl_if.sv
// Interface bundling the button/tick front end and the time/mode outputs
// exchanged between the front end, the clock controller and the display formatter.
interface clock_time_ctrl_if;
    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_pause;
    logic       btn_inc;
    logic [6:0] sec;
    logic [6:0] min;
    logic [6:0] hour;
    logic [1:0] state;
    logic       blink;
    logic       day_cout;

    // Front end / observer side: drives pulses, reads time and mode
    modport master (
        output tick_1hz, btn_mode, btn_pause, btn_inc,
        input  sec, min, hour, state, blink, day_cout
    );

    // Clock controller side: consumes pulses, presents time and mode
    modport slave (
        input  tick_1hz, btn_mode, btn_pause, btn_inc,
        output sec, min, hour, state, blink, day_cout
    );
endinterface

// File: rtl/clock_time_ctrl.sv
// Hour/minute/second counter controller with run/pause/set-hour/set-minute
// mode FSM. All outputs are registered; every input pulse takes effect on
// the next clock edge.
module clock_time_ctrl #(
    parameter int SEC_LIMIT  = 59,
    parameter int MIN_LIMIT  = 59,
    parameter int HOUR_LIMIT = 23,
    parameter int INIT_SEC   = 0,
    parameter int INIT_MIN   = 0,
    parameter int INIT_HOUR  = 0
) (
    input  logic               clk,
    input  logic               rst,
    clock_time_ctrl_if.slave   bus
);

    localparam logic [6:0] SEC_LIM  = 7'(SEC_LIMIT);
    localparam logic [6:0] MIN_LIM  = 7'(MIN_LIMIT);
    localparam logic [6:0] HOUR_LIM = 7'(HOUR_LIMIT);
    localparam logic [6:0] SEC_RST  = 7'(INIT_SEC);
    localparam logic [6:0] MIN_RST  = 7'(INIT_MIN);
    localparam logic [6:0] HOUR_RST = 7'(INIT_HOUR);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_PAUSE   = 2'b01,
        ST_SET_HR  = 2'b10,
        ST_SET_MIN = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] sec_q, sec_d;
    logic [6:0] min_q, min_d;
    logic [6:0] hour_q, hour_d;
    logic       blink_q, blink_d;
    logic       day_cout_q, day_cout_d;

    // Mode state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next mode: btn_mode has priority, btn_pause only toggles RUN/PAUSE
    always_comb begin
        state_d = state_q;
        if (bus.btn_mode) begin
            case (state_q)
                ST_RUN:     state_d = ST_SET_HR;
                ST_PAUSE:   state_d = ST_SET_HR;
                ST_SET_HR:  state_d = ST_SET_MIN;
                ST_SET_MIN: state_d = ST_RUN;
                default:    state_d = ST_RUN;
            endcase
        end else if (bus.btn_pause) begin
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSE;
            end else if (state_q == ST_PAUSE) begin
                state_d = ST_RUN;
            end
        end
    end

    // Next time values, blink strobe and day carry for the current mode
    always_comb begin
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        day_cout_d = 1'b0;
        blink_d    = blink_q;

        case (state_q)
            ST_RUN: begin
                // A mode or pause pulse in the same cycle suppresses the count
                if (bus.tick_1hz && !bus.btn_mode && !bus.btn_pause) begin
                    if (sec_q == SEC_LIM) begin
                        sec_d = 7'd0;
                        if (min_q == MIN_LIM) begin
                            min_d = 7'd0;
                            if (hour_q == HOUR_LIM) begin
                                hour_d     = 7'd0;
                                day_cout_d = 1'b1;
                            end else begin
                                hour_d = hour_q + 7'd1;
                            end
                        end else begin
                            min_d = min_q + 7'd1;
                        end
                    end else begin
                        sec_d = sec_q + 7'd1;
                    end
                end
            end
            ST_SET_HR: begin
                if (bus.btn_inc && !bus.btn_mode) begin
                    hour_d = (hour_q == HOUR_LIM) ? 7'd0 : hour_q + 7'd1;
                end
            end
            ST_SET_MIN: begin
                if (bus.btn_mode) begin
                    // Returning to RUN restarts the minute from second zero
                    sec_d = 7'd0;
                end else if (bus.btn_inc) begin
                    min_d = (min_q == MIN_LIM) ? 7'd0 : min_q + 7'd1;
                end
            end
            default: ;
        endcase

        if (state_d == ST_RUN || state_d == ST_PAUSE) begin
            blink_d = 1'b0;
        end else if (bus.tick_1hz && (state_q == ST_SET_HR || state_q == ST_SET_MIN)) begin
            blink_d = ~blink_q;
        end
    end

    // Time, blink and carry registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sec_q      <= SEC_RST;
            min_q      <= MIN_RST;
            hour_q     <= HOUR_RST;
            blink_q    <= 1'b0;
            day_cout_q <= 1'b0;
        end else begin
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            blink_q    <= blink_d;
            day_cout_q <= day_cout_d;
        end
    end

    assign bus.sec      = sec_q;
    assign bus.min      = min_q;
    assign bus.hour     = hour_q;
    assign bus.state    = state_q;
    assign bus.blink    = blink_q;
    assign bus.day_cout = day_cout_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Scoreboard bench for clock_time_ctrl: the driver issues one input vector
// per cycle and queues its hand-computed expected outputs; the monitor pops
// one entry per cycle after the edge and compares where a check is flagged.
module tb_clock_time_ctrl;

    logic clk;
    logic rst;
    clock_time_ctrl_if bus();

    clock_time_ctrl #(
        .SEC_LIMIT (59),
        .MIN_LIMIT (59),
        .HOUR_LIMIT(23),
        .INIT_SEC  (58),
        .INIT_MIN  (59),
        .INIT_HOUR (23)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        bit    chk;
        string name;
        int    sec;
        int    min;
        int    hour;
        int    st;
        int    blink;
        int    dc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   drive_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one input vector at the falling edge and queue its expectation
    task automatic step(input bit r, input bit t, input bit m, input bit p, input bit i,
                        input bit chk, input string nm,
                        input int es, input int em, input int eh,
                        input int est, input int eb, input int edc);
        exp_t e;
        @(negedge clk);
        rst           = r;
        bus.tick_1hz  = t;
        bus.btn_mode  = m;
        bus.btn_pause = p;
        bus.btn_inc   = i;
        e.chk   = chk;
        e.name  = nm;
        e.sec   = es;
        e.min   = em;
        e.hour  = eh;
        e.st    = est;
        e.blink = eb;
        e.dc    = edc;
        sb.push_back(e);
    endtask

    // Monitor: one queued expectation per clock, compared just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk) begin
                    checks++;
                    if (int'(bus.sec) != e.sec || int'(bus.min) != e.min ||
                        int'(bus.hour) != e.hour || int'(bus.state) != e.st ||
                        int'(bus.blink) != e.blink || int'(bus.day_cout) != e.dc) begin
                        errors++;
                        $display("FAIL %s: got %0d:%0d:%0d st=%0d blink=%0d dc=%0d, want %0d:%0d:%0d st=%0d blink=%0d dc=%0d",
                                 e.name, bus.hour, bus.min, bus.sec, bus.state, bus.blink, bus.day_cout,
                                 e.hour, e.min, e.sec, e.st, e.blink, e.dc);
                    end
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        rst           = 1'b1;
        bus.tick_1hz  = 1'b0;
        bus.btn_mode  = 1'b0;
        bus.btn_pause = 1'b0;
        bus.btn_inc   = 1'b0;

        step(1, 0, 0, 0, 0, 1, "reset",        58, 59, 23, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1, "tick_to_59",   59, 59, 23, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1, "day_rollover",  0,  0,  0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, "dcout_clear",   0,  0,  0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1, "pause",         0,  0,  0, 1, 0, 0);
        for (int k = 0; k < 5; k++)
            step(0, 1, 0, 0, 0, k == 4, "pause_ticks", 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 1, "pause_inc",     0,  0,  0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 1, "resume",        0,  0,  0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1, "run_tick",      1,  0,  0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 1, "tick_w_pause",  1,  0,  0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 1, "resume2",       1,  0,  0, 0, 0, 0);
        for (int k = 0; k < 36; k++)
            step(0, 1, 0, 0, 0, k == 35, "sec_to_37", 37, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 1, "mode_w_pause", 37,  0,  0, 2, 0, 0);
        step(0, 1, 0, 0, 0, 1, "sethr_tick",   37,  0,  0, 2, 1, 0);
        for (int k = 0; k < 25; k++)
            step(0, 0, 0, 0, 1, k == 24, "hr_inc25", 37, 0, 1, 2, 1, 0);
        step(0, 0, 1, 0, 1, 1, "mode_w_inc",   37,  0,  1, 3, 1, 0);
        for (int k = 0; k < 61; k++)
            step(0, 0, 0, 0, 1, k == 60, "min_inc61", 37, 1, 1, 3, 1, 0);
        step(0, 1, 0, 0, 0, 1, "setmin_tick1", 37,  1,  1, 3, 0, 0);
        step(0, 1, 0, 0, 0, 1, "setmin_tick2", 37,  1,  1, 3, 1, 0);
        step(0, 0, 1, 0, 0, 1, "leave_setmin",  0,  1,  1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 1, "tick_w_mode",   0,  1,  1, 2, 0, 0);
        step(0, 0, 0, 1, 0, 1, "sethr_pause",   0,  1,  1, 2, 0, 0);
        for (int k = 0; k < 11; k++)
            step(0, 0, 0, 0, 1, k == 10, "hr_to_12", 0, 1, 12, 2, 0, 0);
        step(0, 0, 1, 0, 0, 1, "to_setmin",     0,  1, 12, 3, 0, 0);
        for (int k = 0; k < 33; k++)
            step(0, 0, 0, 0, 1, k == 32, "min_to_34", 0, 34, 12, 3, 0, 0);
        step(1, 1, 0, 0, 1, 1, "mid_reset",    58, 59, 23, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, "post_reset",   58, 59, 23, 0, 0, 0);

        @(negedge clk);
        rst           = 1'b0;
        bus.tick_1hz  = 1'b0;
        bus.btn_mode  = 1'b0;
        bus.btn_pause = 1'b0;
        bus.btn_inc   = 1'b0;
        drive_done    = 1'b1;
    end

    // Drain the scoreboard with a bounded wait, then report
    initial begin
        int budget;
        wait (drive_done);
        budget = 20;
        while (sb.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
